// File: rtl/bcd_countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_countdown_timer_if
//  Description : Control and status bundle for the BCD countdown timer.
//                The master side drives the tick, load and run controls.
//                The slave side (the timer) returns the count and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_countdown_timer_if;
    logic       tick_in;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       tick_seen;
    logic       load_err;

    modport master (
        output tick_in, load, load_min, load_sec, start, pause,
        input  min_bcd, sec_bcd, running, done, tick_seen, load_err
    );

    modport slave (
        input  tick_in, load, load_min, load_sec, start, pause,
        output min_bcd, sec_bcd, running, done, tick_seen, load_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_countdown_timer
//  Description : BCD minutes:seconds countdown.  The slow tick from the
//                divider is synchronized and edge-detected as data, and each
//                rising edge decrements the count while running.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int         SYNC_STAGES = 2,      // must be 2 or more
    parameter logic [7:0] MAX_MIN     = 8'h59
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                   r_state_q,     w_state_d;
    logic [7:0]               r_min_q,       w_min_d;
    logic [7:0]               r_sec_q,       w_sec_d;
    logic [SYNC_STAGES-1:0]   r_sync_q,      w_sync_d;
    logic                     r_prev_q,      w_prev_d;
    logic                     r_running_q,   w_running_d;
    logic                     r_done_q,      w_done_d;
    logic                     r_tick_seen_q, w_tick_seen_d;
    logic                     r_load_err_q,  w_load_err_d;

    logic                     w_tick_edge;
    logic                     w_load_ok;
    logic [7:0]               w_dec_min;
    logic [7:0]               w_dec_sec;
    logic                     w_dec_zero;
    logic                     w_count_zero;

    // Synchronizer shift and rising-edge detect on the slow tick
    always_comb begin
        w_sync_d      = {r_sync_q[SYNC_STAGES-2:0], bus.tick_in};
        w_prev_d      = r_sync_q[SYNC_STAGES-1];
        w_tick_edge   = r_sync_q[SYNC_STAGES-1] & ~r_prev_q;
        w_tick_seen_d = w_tick_edge;
    end

    // Load value legality: BCD digits, seconds at most 59, minutes within range
    always_comb begin
        w_load_ok = (bus.load_min[7:4] <= 4'd9) && (bus.load_min[3:0] <= 4'd9) &&
                    (bus.load_sec[3:0] <= 4'd9) && (bus.load_sec <= 8'h59) &&
                    (bus.load_min <= MAX_MIN);
    end

    // One-second BCD decrement of the current count with borrow into minutes
    always_comb begin
        w_dec_min = r_min_q;
        w_dec_sec = r_sec_q;
        if (r_sec_q[3:0] != 4'd0) begin
            w_dec_sec[3:0] = r_sec_q[3:0] - 4'd1;
        end else if (r_sec_q[7:4] != 4'd0) begin
            w_dec_sec = {r_sec_q[7:4] - 4'd1, 4'd9};
        end else if (r_min_q != 8'h00) begin
            w_dec_sec = 8'h59;
            if (r_min_q[3:0] != 4'd0) begin
                w_dec_min[3:0] = r_min_q[3:0] - 4'd1;
            end else begin
                w_dec_min = {r_min_q[7:4] - 4'd1, 4'd9};
            end
        end
        w_dec_zero   = (w_dec_min == 8'h00) && (w_dec_sec == 8'h00);
        w_count_zero = (r_min_q == 8'h00) && (r_sec_q == 8'h00);
    end

    // Control FSM: load > pause > start > tick; status flags follow next state
    always_comb begin
        w_state_d    = r_state_q;
        w_min_d      = r_min_q;
        w_sec_d      = r_sec_q;
        w_load_err_d = 1'b0;

        if (bus.load) begin
            // A load owns the whole cycle, whether accepted or rejected
            if (w_load_ok) begin
                w_min_d   = bus.load_min;
                w_sec_d   = bus.load_sec;
                w_state_d = ST_IDLE;
            end else begin
                w_load_err_d = 1'b1;
            end
        end else if (bus.pause && (r_state_q == ST_RUN)) begin
            // Any coincident tick is dropped here
            w_state_d = ST_PAUSED;
        end else if (bus.start && ((r_state_q == ST_IDLE) || (r_state_q == ST_PAUSED))) begin
            // Any coincident tick is dropped; an empty count finishes at once
            w_state_d = w_count_zero ? ST_DONE : ST_RUN;
        end else if (w_tick_edge && (r_state_q == ST_RUN)) begin
            w_min_d = w_dec_min;
            w_sec_d = w_dec_sec;
            if (w_dec_zero) begin
                w_state_d = ST_DONE;
            end
        end

        w_running_d = (w_state_d == ST_RUN);
        w_done_d    = (w_state_d == ST_DONE);
    end

    // State, count and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_min_q       <= 8'h00;
            r_sec_q       <= 8'h00;
            r_sync_q      <= '0;
            r_prev_q      <= 1'b0;
            r_running_q   <= 1'b0;
            r_done_q      <= 1'b0;
            r_tick_seen_q <= 1'b0;
            r_load_err_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_min_q       <= w_min_d;
            r_sec_q       <= w_sec_d;
            r_sync_q      <= w_sync_d;
            r_prev_q      <= w_prev_d;
            r_running_q   <= w_running_d;
            r_done_q      <= w_done_d;
            r_tick_seen_q <= w_tick_seen_d;
            r_load_err_q  <= w_load_err_d;
        end
    end

    assign bus.min_bcd   = r_min_q;
    assign bus.sec_bcd   = r_sec_q;
    assign bus.running   = r_running_q;
    assign bus.done      = r_done_q;
    assign bus.tick_seen = r_tick_seen_q;
    assign bus.load_err  = r_load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_countdown_timer
//  Description : Directed self-checking bench for bcd_countdown_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bcd_countdown_timer_if bus ();

    bcd_countdown_timer #(
        .SYNC_STAGES (2),
        .MAX_MIN     (8'h59)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: drive only, no checking
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick_in = 1'b1;
        step(3);
        bus.tick_in = 1'b0;
        step(3);
    endtask

    task automatic pulse_load(input logic [7:0] m, input logic [7:0] s);
        bus.load_min = m;
        bus.load_sec = s;
        bus.load     = 1'b1;
        step(1);
        bus.load     = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tick_in = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.load_min = 8'h00; bus.load_sec = 8'h00;
        step(1);
        bus.tick_in = 1'b1;
        step(1);
        bus.tick_in = 1'b0;
        checks++; if (bus.min_bcd !== 8'h00) begin errors++; $display("FAIL reset_min: got %h want 00", bus.min_bcd); end
        checks++; if (bus.sec_bcd !== 8'h00) begin errors++; $display("FAIL reset_sec: got %h want 00", bus.sec_bcd); end
        checks++; if (bus.running !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_flags: got run=%b done=%b want 0 0", bus.running, bus.done); end
        checks++; if (bus.tick_seen !== 1'b0 || bus.load_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got seen=%b err=%b want 0 0", bus.tick_seen, bus.load_err); end
        rst = 1'b0;
        step(4);
        do_tick();
        do_tick();
        checks++; if (bus.min_bcd !== 8'h00 || bus.sec_bcd !== 8'h00 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_ticks: got %h:%h run=%b want 00:00 0", bus.min_bcd, bus.sec_bcd, bus.running); end
    endtask

    task automatic test_full_countdown();
        pulse_load(8'h01, 8'h00);
        checks++; if (bus.min_bcd !== 8'h01 || bus.sec_bcd !== 8'h00 || bus.running !== 1'b0) begin errors++; $display("FAIL load_0100: got %h:%h run=%b want 01:00 0", bus.min_bcd, bus.sec_bcd, bus.running); end
        pulse_start();
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL start_run: got %b want 1", bus.running); end
        do_tick();
        checks++; if (bus.min_bcd !== 8'h00 || bus.sec_bcd !== 8'h59) begin errors++; $display("FAIL first_dec: got %h:%h want 00:59", bus.min_bcd, bus.sec_bcd); end
        for (int i = 0; i < 58; i++) do_tick();
        checks++; if (bus.sec_bcd !== 8'h01 || bus.running !== 1'b1) begin errors++; $display("FAIL at_0001: got %h run=%b want 01 1", bus.sec_bcd, bus.running); end
        bus.tick_in = 1'b1;
        step(2);
        checks++; if (bus.sec_bcd !== 8'h01 || bus.running !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL pre_final: got %h run=%b done=%b want 01 1 0", bus.sec_bcd, bus.running, bus.done); end
        step(1);
        checks++; if (bus.sec_bcd !== 8'h00 || bus.min_bcd !== 8'h00 || bus.done !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL final_done: got %h:%h run=%b done=%b want 00:00 0 1", bus.min_bcd, bus.sec_bcd, bus.running, bus.done); end
        bus.tick_in = 1'b0;
        step(3);
        do_tick();
        pulse_start();
        checks++; if (bus.sec_bcd !== 8'h00 || bus.done !== 1'b1) begin errors++; $display("FAIL done_hold: got %h done=%b want 00 1", bus.sec_bcd, bus.done); end
    endtask

    task automatic test_latency();
        int pulses;
        pulse_load(8'h00, 8'h10);
        pulse_start();
        bus.tick_in = 1'b1;
        step(1);
        checks++; if (bus.sec_bcd !== 8'h10 || bus.tick_seen !== 1'b0) begin errors++; $display("FAIL lat_k: got %h seen=%b want 10 0", bus.sec_bcd, bus.tick_seen); end
        step(1);
        checks++; if (bus.sec_bcd !== 8'h10 || bus.tick_seen !== 1'b0) begin errors++; $display("FAIL lat_k1: got %h seen=%b want 10 0", bus.sec_bcd, bus.tick_seen); end
        step(1);
        checks++; if (bus.sec_bcd !== 8'h09 || bus.tick_seen !== 1'b1) begin errors++; $display("FAIL lat_k2: got %h seen=%b want 09 1", bus.sec_bcd, bus.tick_seen); end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus.tick_seen === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL held_pulses: got %0d want 0", pulses); end
        checks++; if (bus.sec_bcd !== 8'h09) begin errors++; $display("FAIL held_count: got %h want 09", bus.sec_bcd); end
        bus.tick_in = 1'b0;
        step(3);
    endtask

    task automatic test_pause_resume();
        pulse_load(8'h00, 8'h30);
        pulse_start();
        bus.tick_in = 1'b1;
        step(2);
        bus.pause = 1'b1;
        step(1);
        bus.pause = 1'b0;
        checks++; if (bus.sec_bcd !== 8'h30 || bus.running !== 1'b0 || bus.tick_seen !== 1'b1) begin errors++; $display("FAIL pause_tick: got %h run=%b seen=%b want 30 0 1", bus.sec_bcd, bus.running, bus.tick_seen); end
        bus.tick_in = 1'b0;
        step(3);
        do_tick(); do_tick(); do_tick();
        checks++; if (bus.sec_bcd !== 8'h30 || bus.running !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL paused_ticks: got %h run=%b done=%b want 30 0 0", bus.sec_bcd, bus.running, bus.done); end
        pulse_start();
        checks++; if (bus.running !== 1'b1 || bus.sec_bcd !== 8'h30) begin errors++; $display("FAIL resume: got %h run=%b want 30 1", bus.sec_bcd, bus.running); end
        do_tick();
        checks++; if (bus.sec_bcd !== 8'h29) begin errors++; $display("FAIL resume_dec: got %h want 29", bus.sec_bcd); end
        bus.pause = 1'b1;
        step(1);
        bus.pause = 1'b0;
        bus.tick_in = 1'b1;
        step(2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        checks++; if (bus.running !== 1'b1 || bus.sec_bcd !== 8'h29) begin errors++; $display("FAIL start_tick: got %h run=%b want 29 1", bus.sec_bcd, bus.running); end
        bus.tick_in = 1'b0;
        step(3);
        do_tick();
        checks++; if (bus.sec_bcd !== 8'h28) begin errors++; $display("FAIL after_start_tick: got %h want 28", bus.sec_bcd); end
    endtask

    task automatic test_invalid_load();
        pulse_load(8'h00, 8'h5A);
        checks++; if (bus.load_err !== 1'b1 || bus.sec_bcd !== 8'h28 || bus.running !== 1'b1) begin errors++; $display("FAIL bad_sec: got err=%b %h run=%b want 1 28 1", bus.load_err, bus.sec_bcd, bus.running); end
        step(1);
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", bus.load_err); end
        pulse_load(8'h60, 8'h00);
        checks++; if (bus.load_err !== 1'b1 || bus.min_bcd !== 8'h00 || bus.sec_bcd !== 8'h28 || bus.running !== 1'b1) begin errors++; $display("FAIL bad_min: got err=%b %h:%h run=%b want 1 00:28 1", bus.load_err, bus.min_bcd, bus.sec_bcd, bus.running); end
        pulse_load(8'h0A, 8'h00);
        checks++; if (bus.load_err !== 1'b1 || bus.sec_bcd !== 8'h28) begin errors++; $display("FAIL bad_nibble: got err=%b %h want 1 28", bus.load_err, bus.sec_bcd); end
        pulse_load(8'h59, 8'h59);
        checks++; if (bus.load_err !== 1'b0 || bus.min_bcd !== 8'h59 || bus.sec_bcd !== 8'h59 || bus.running !== 1'b0) begin errors++; $display("FAIL max_load: got err=%b %h:%h run=%b want 0 59:59 0", bus.load_err, bus.min_bcd, bus.sec_bcd, bus.running); end
        pulse_load(8'h00, 8'h00);
        pulse_start();
        checks++; if (bus.done !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL zero_start: got done=%b run=%b want 1 0", bus.done, bus.running); end
    endtask

    task automatic test_wrap_reset();
        pulse_load(8'h10, 8'h00);
        pulse_start();
        do_tick();
        checks++; if (bus.min_bcd !== 8'h09 || bus.sec_bcd !== 8'h59) begin errors++; $display("FAIL wrap: got %h:%h want 09:59", bus.min_bcd, bus.sec_bcd); end
        do_tick();
        checks++; if (bus.min_bcd !== 8'h09 || bus.sec_bcd !== 8'h58) begin errors++; $display("FAIL wrap_next: got %h:%h want 09:58", bus.min_bcd, bus.sec_bcd); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (bus.min_bcd !== 8'h00 || bus.sec_bcd !== 8'h00 || bus.running !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst: got %h:%h run=%b done=%b want 00:00 0 0", bus.min_bcd, bus.sec_bcd, bus.running, bus.done); end
        pulse_start();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rst_then_start: got done=%b want 1", bus.done); end
        pulse_load(8'h00, 8'h05);
        checks++; if (bus.done !== 1'b0 || bus.running !== 1'b0 || bus.sec_bcd !== 8'h05) begin errors++; $display("FAIL load_in_done: got %h run=%b done=%b want 05 0 0", bus.sec_bcd, bus.running, bus.done); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_full_countdown();
        test_latency();
        test_pause_resume();
        test_invalid_load();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Consumes the slow square-wave tick produced by the clock-divider stage and runs a BCD minutes:seconds countdown from a loaded value. There is one decrement per rising edge of the tick. The block is fully synchronous to the system clock. The tick is treated as data: it is synchronized and edge-detected, never used as a clock. Its outputs feed the display/scan stage and the game/control FSM.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the tick_in synchronizer (min 2).
MAX_MIN, 8'h59, largest legal minutes value, in BCD.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick_in  input  1  slow square wave from the divider stage
load  input  1  one-cycle pulse: load load_min/load_sec
load_min  input  8  BCD minutes {tens,ones}
load_sec  input  8  BCD seconds {tens,ones}
start  input  1  one-cycle pulse: start or resume countdown
pause  input  1  one-cycle pulse: pause countdown
min_bcd  output  8  current minutes, BCD
sec_bcd  output  8  current seconds, BCD
running  output  1  high while in RUN
done  output  1  level, high while in DONE
tick_seen  output  1  one-cycle pulse for each detected tick rising edge
load_err  output  1  one-cycle pulse: load rejected

Behaviour:
- Reset (sampled at posedge clk while rst=1):
  - state=IDLE.
  - min_bcd=8'h00, sec_bcd=8'h00.
  - synchronizer chain and edge-detect register cleared to 0.
  - running=0, done=0, tick_seen=0, load_err=0.
  - rst overrides every other input in the same cycle, including mid-countdown.
- Tick detection:
  - tick_in passes through the SYNC_STAGES flip-flops, then the edge-detect register.
  - tick_edge = sync_out & ~prev.
  - If tick_in is first sampled high at clk edge k, the tick takes effect at edge k+SYNC_STAGES: the count update happens there and tick_seen is high for the following cycle.
  - Detection runs in every state, so no edge is double-counted or replayed across pause/resume.
  - If tick_in is high at reset release, one edge is produced; it has no effect outside RUN.
- States: IDLE, RUN, PAUSED, DONE.
- Priority within one cycle: rst > load > pause > start > tick.
- load (any state):
  - Accepted only if every nibble is <=9, load_sec<=8'h59 and load_min<=MAX_MIN.
  - If accepted: registers take the value at the next edge and state becomes IDLE.
  - If rejected: count and state are unchanged and load_err pulses for 1 cycle.
- start:
  - IDLE or PAUSED -> RUN.
  - If the count is 00:00 when start is accepted, go -> DONE instead.
  - Ignored in RUN and DONE.
- pause:
  - RUN -> PAUSED.
  - Ignored in other states.
  - A tick in the same cycle is discarded.
- tick_edge in RUN decrements the count:
  - if sec ones!=0: sec ones-1;
  - else if sec tens!=0: sec tens-1, ones=9;
  - else if min!=00: sec=8'h59, min BCD-decrement (ones wraps 0->9 with tens-1);
  - if the result is 00:00, the state becomes DONE on the same edge.
- A tick in any state other than RUN leaves the count unchanged, but tick_seen still pulses.
- start in PAUSED coinciding with a tick: the state goes to RUN and that tick is not applied.
- running = (state==RUN); done = (state==DONE). Both are registered state decodes, with no glitch on transition.
- DONE holds 00:00 until load or rst.
- min_bcd/sec_bcd never hold a non-BCD digit or sec>59.

Test Plan:
- Reset then idle: rst high 2 cycles with tick_in toggling -> min_bcd=00, sec_bcd=00, running=0, done=0; ticks cause no count change.
- Load 01:00, start, apply 1 tick -> 00:59; 59 more ticks -> 00:00 with done=1 and running=0 on the same edge as the final decrement.
- Latency check (SYNC_STAGES=2): tick_in rises just before edge k in RUN at 00:10 -> sec_bcd=09 after edge k+2; tick_seen high exactly 1 cycle; tick_in held high for 100 cycles -> only one decrement.
- Pause/resume: at 00:30 assert pause in the same cycle as tick_edge -> stays 00:30 in PAUSED; 3 ticks -> unchanged; start -> RUN, next tick -> 00:29.
- Invalid load: load_sec=8'h5A, then load_min=8'h60 with MAX_MIN=8'h59 -> each gives a load_err pulse and the count/state are unchanged; load 00:00 then start -> DONE next cycle.
- Wrap and reset: load 10:00, start, 1 tick -> 09:59; rst asserted mid-RUN -> 00:00 and IDLE next edge; load during DONE -> IDLE with the new value.
